// File: rtl/text_console_writer.sv
// text_console_writer
// Turns a CPU byte stream of character/control codes into frame-memory write
// cycles for a COLS x ROWS text display, one cell written per clock.
//
// Optional feature: define TEXT_CONSOLE_TAB_EN to make 0x09 advance to the
// next multiple-of-8 column, clearing each skipped cell. Without it 0x09 is
// consumed and ignored.
//
// Ports:
//   SysClk      system clock (single domain)
//   ResetN      asynchronous active-low reset; a full-screen clear follows release
//   CharValid   byte offered on CharData
//   CharData    character/control code
//   CharReady   byte accepted on the edge where CharValid && CharReady
//   WrtFrameMem frame-memory write strobe, one cell per cycle
//   AdrOut      frame-memory address, row*COLS+col
//   DataOut     frame-memory write data
//   CursorCol   current column
//   CursorRow   current row
//   Busy        clear sequence in progress
module text_console_writer #(
    parameter int unsigned COLS       = 40,
    parameter int unsigned ROWS       = 25,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
    input  logic       SysClk,
    input  logic       ResetN,
    input  logic       CharValid,
    input  logic [7:0] CharData,
    output logic       CharReady,
    output logic       WrtFrameMem,
    output logic [9:0] AdrOut,
    output logic [7:0] DataOut,
    output logic [5:0] CursorCol,
    output logic [4:0] CursorRow,
    output logic       Busy
);

    localparam logic [9:0] CELLS_W   = 10'(COLS * ROWS);
    localparam logic [9:0] COLS_W    = 10'(COLS);
    localparam logic [9:0] ROW_END   = 10'(COLS - 1);
    localparam logic [5:0] COL_LAST  = 6'(COLS - 1);
    localparam logic [4:0] ROW_LAST  = 5'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLR_ROW,
        CLR_SCREEN
`ifdef TEXT_CONSOLE_TAB_EN
        , TAB
`endif
    } state_t;

    state_t     state, state_d;
    logic [9:0] cnt, cnt_d;
    logic [9:0] base, base_d;
    logic [5:0] col_d;
    logic [4:0] row_d;
    logic       wrt_d, ready_d, busy_d;
    logic [9:0] adr_d;
    logic [7:0] dat_d;
    logic [4:0] adv_row;
    logic [9:0] adv_base;
    logic [9:0] cur_adr;
    logic       accept;

`ifdef TEXT_CONSOLE_TAB_EN
    logic [6:0] tab_stop;
    assign tab_stop = {1'b0, CursorCol[5:3], 3'b000} + 7'd8;
`endif

    assign accept  = CharValid && CharReady;
    assign cur_adr = base + {4'b0000, CursorCol};

    // Row base moves by COLS steps; the wrap to row 0 reloads zero.
    always_comb begin
        if (CursorRow == ROW_LAST) begin
            adv_row  = '0;
            adv_base = '0;
        end else begin
            adv_row  = CursorRow + 5'd1;
            adv_base = base + COLS_W;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        base_d  = base;
        col_d   = CursorCol;
        row_d   = CursorRow;
        wrt_d   = 1'b0;
        adr_d   = AdrOut;
        dat_d   = DataOut;

        case (state)
            // Counts one past the last cell so Busy still covers the final write.
            CLR_SCREEN: begin
                if (cnt == CELLS_W) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    base_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    wrt_d = 1'b1;
                    adr_d = cnt;
                    dat_d = CLEAR_CHAR;
                    cnt_d = cnt + 10'd1;
                end
            end
            CLR_ROW: begin
                wrt_d = 1'b1;
                adr_d = base + cnt;
                dat_d = CLEAR_CHAR;
                if (cnt == ROW_END) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 10'd1;
                end
            end
`ifdef TEXT_CONSOLE_TAB_EN
            TAB: begin
                wrt_d = 1'b1;
                adr_d = cur_adr;
                dat_d = CLEAR_CHAR;
                col_d = CursorCol + 6'd1;
                if (col_d[2:0] == 3'b000) state_d = IDLE;
            end
`endif
            IDLE: begin
                if (accept) begin
                    if (CharData >= 8'h20 && CharData <= 8'h7E) begin
                        wrt_d = 1'b1;
                        adr_d = cur_adr;
                        dat_d = CharData;
                        if (CursorCol == COL_LAST) begin
                            col_d   = '0;
                            row_d   = adv_row;
                            base_d  = adv_base;
                            cnt_d   = '0;
                            state_d = CLR_ROW;
                        end else begin
                            col_d = CursorCol + 6'd1;
                        end
                    end else begin
                        case (CharData)
                            8'h0D: col_d = '0;
                            8'h0A: begin
                                col_d   = '0;
                                row_d   = adv_row;
                                base_d  = adv_base;
                                cnt_d   = '0;
                                state_d = CLR_ROW;
                            end
                            8'h08: begin
                                if (CursorCol != '0) begin
                                    col_d = CursorCol - 6'd1;
                                    wrt_d = 1'b1;
                                    adr_d = cur_adr - 10'd1;
                                    dat_d = CLEAR_CHAR;
                                end
                            end
                            8'h0C: begin
                                cnt_d   = '0;
                                state_d = CLR_SCREEN;
                            end
`ifdef TEXT_CONSOLE_TAB_EN
                            8'h09: begin
                                if (tab_stop >= 7'(COLS)) begin
                                    col_d   = '0;
                                    row_d   = adv_row;
                                    base_d  = adv_base;
                                    cnt_d   = '0;
                                    state_d = CLR_ROW;
                                end else begin
                                    // First skipped cell goes out on the accept edge.
                                    wrt_d = 1'b1;
                                    adr_d = cur_adr;
                                    dat_d = CLEAR_CHAR;
                                    col_d = CursorCol + 6'd1;
                                    if (col_d[2:0] != 3'b000) state_d = TAB;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags follow the next state so CharReady means "IDLE now".
        ready_d = (state_d == IDLE);
        busy_d  = !ready_d;
    end

    always_ff @(posedge SysClk or negedge ResetN) begin
        if (!ResetN) begin
            state       <= CLR_SCREEN;
            cnt         <= '0;
            base        <= '0;
            CursorCol   <= '0;
            CursorRow   <= '0;
            WrtFrameMem <= 1'b0;
            AdrOut      <= '0;
            DataOut     <= '0;
            CharReady   <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            base        <= base_d;
            CursorCol   <= col_d;
            CursorRow   <= row_d;
            WrtFrameMem <= wrt_d;
            AdrOut      <= adr_d;
            DataOut     <= dat_d;
            CharReady   <= ready_d;
            Busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: a reset/init sequence, a table
// of single-byte vectors, hand-written multi-cycle corner cases and random
// byte streams, all compared against a cell-level model of the console.
module tb_text_console_writer;

    logic       SysClk = 1'b0;
    logic       ResetN = 1'b0;
    logic       CharValid = 1'b0;
    logic [7:0] CharData = 8'h00;
    logic       CharReady;
    logic       WrtFrameMem;
    logic [9:0] AdrOut;
    logic [7:0] DataOut;
    logic [5:0] CursorCol;
    logic [4:0] CursorRow;
    logic       Busy;

    text_console_writer #(.COLS(40), .ROWS(25), .CLEAR_CHAR(8'h20)) dut (
        .SysClk      (SysClk),
        .ResetN      (ResetN),
        .CharValid   (CharValid),
        .CharData    (CharData),
        .CharReady   (CharReady),
        .WrtFrameMem (WrtFrameMem),
        .AdrOut      (AdrOut),
        .DataOut     (DataOut),
        .CursorCol   (CursorCol),
        .CursorRow   (CursorRow),
        .Busy        (Busy)
    );

    always #5 SysClk = ~SysClk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    logic [17:0] act[$];
    logic [17:0] expq[$];
    int          act_cyc[$];

    // Console model: cursor position plus the list of cells expected to be written.
    int m_col = 0;
    int m_row = 0;

    always @(posedge SysClk) cyc++;

    always @(negedge SysClk) begin
        if (ResetN) begin
            if (WrtFrameMem) begin
                act.push_back({AdrOut, DataOut});
                act_cyc.push_back(cyc);
            end
            if (mon_en) begin
                vectors++;
                if ((Busy && CharReady) || AdrOut > 10'd999) begin
                    miscompares++;
                    $display("FAIL invariant: Busy=%0b CharReady=%0b AdrOut=%0d (required Busy/CharReady exclusive, AdrOut<=999)",
                             Busy, CharReady, AdrOut);
                end
            end
        end
    end

    function automatic void push_clear_row(int r);
        for (int i = 0; i < 40; i++) expq.push_back({10'(r * 40 + i), 8'h20});
    endfunction

    function automatic void push_clear_screen();
        for (int i = 0; i < 1000; i++) expq.push_back({10'(i), 8'h20});
    endfunction

    function automatic void advance_row();
        m_col = 0;
        m_row = (m_row + 1) % 25;
        push_clear_row(m_row);
    endfunction

    function automatic void model_byte(logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            expq.push_back({10'(m_row * 40 + m_col), c});
            m_col++;
            if (m_col == 40) advance_row();
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h0A) begin
            advance_row();
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                expq.push_back({10'(m_row * 40 + m_col), 8'h20});
            end
        end else if (c == 8'h0C) begin
            push_clear_screen();
            m_col = 0;
            m_row = 0;
        end
`ifdef TEXT_CONSOLE_TAB_EN
        else if (c == 8'h09) begin
            int tgt;
            tgt = (m_col / 8 + 1) * 8;
            if (tgt >= 40) advance_row();
            else while (m_col < tgt) begin
                expq.push_back({10'(m_row * 40 + m_col), 8'h20});
                m_col++;
            end
        end
`endif
    endfunction

    task automatic check(input string nm, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", nm, got, want);
        end
    endtask

    task automatic check_writes(input string nm);
        int bad;
        int idx;
        bad = 0;
        idx = -1;
        vectors++;
        if (act.size() != expq.size()) bad = 1;
        for (int i = 0; i < act.size() && i < expq.size(); i++) begin
            if (act[i] != expq[i] && idx < 0) begin
                idx = i;
                bad = 1;
            end
        end
        if (bad) begin
            miscompares++;
            if (idx >= 0)
                $display("FAIL %s: write #%0d got adr=%0d data=%02h required adr=%0d data=%02h (counts %0d/%0d)",
                         nm, idx, act[idx][17:8], act[idx][7:0], expq[idx][17:8], expq[idx][7:0],
                         act.size(), expq.size());
            else
                $display("FAIL %s: got %0d writes required %0d", nm, act.size(), expq.size());
        end
        act.delete();
        act_cyc.delete();
        expq.delete();
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        CharData  = c;
        CharValid = 1'b1;
        n = 0;
        while (!CharReady && n < 3000) begin
            @(posedge SysClk); #1;
            n++;
        end
        if (!CharReady) begin
            check($sformatf("send_timeout_%02h", c), 0, 1);
        end else begin
            @(posedge SysClk); #1;
        end
        CharValid = 1'b0;
    endtask

    task automatic wait_idle(output int low);
        low = 0;
        while (!CharReady && low < 3000) begin
            @(posedge SysClk); #1;
            low++;
        end
        if (!CharReady) check("idle_timeout", 0, 1);
        @(negedge SysClk); #1;
    endtask

    task automatic send_chk(input logic [7:0] c, output int low, output int nwr);
        model_byte(c);
        send(c);
        wait_idle(low);
        nwr = act.size();
        check($sformatf("col_after_%02h", c), int'(CursorCol), m_col);
        check($sformatf("row_after_%02h", c), int'(CursorRow), m_row);
        check_writes($sformatf("writes_after_%02h", c));
    endtask

    typedef struct {
        logic [7:0] ch;
        int         col;
        int         row;
        int         nwr;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int low;
        int nwr;
        logic [7:0] c;
        int r;

        // Starting from cursor (0,0) after the init clear.
        tbl[0]  = '{8'h0D, 0, 0, 0};
        tbl[1]  = '{8'h07, 0, 0, 0};
        tbl[2]  = '{8'h08, 0, 0, 0};
        tbl[3]  = '{8'h78, 1, 0, 1};
        tbl[4]  = '{8'h08, 0, 0, 1};
        tbl[5]  = '{8'h0A, 0, 1, 40};
        tbl[6]  = '{8'h80, 0, 1, 0};
        tbl[7]  = '{8'hFF, 0, 1, 0};
        tbl[8]  = '{8'h7E, 1, 1, 1};
        tbl[9]  = '{8'h1F, 1, 1, 0};
        tbl[10] = '{8'h20, 2, 1, 1};
        tbl[11] = '{8'h7F, 2, 1, 0};
        tbl[12] = '{8'h41, 3, 1, 1};
        tbl[13] = '{8'h0D, 0, 1, 0};
        tbl[14] = '{8'h0A, 0, 2, 40};
        tbl[15] = '{8'h00, 0, 2, 0};

        // Reset values.
        repeat (3) @(posedge SysClk);
        #1;
        check("rst_wrt",   int'(WrtFrameMem), 0);
        check("rst_adr",   int'(AdrOut), 0);
        check("rst_data",  int'(DataOut), 0);
        check("rst_col",   int'(CursorCol), 0);
        check("rst_row",   int'(CursorRow), 0);
        check("rst_ready", int'(CharReady), 0);
        check("rst_busy",  int'(Busy), 0);

        // Release: full-screen clear, one cell per cycle with Busy high.
        @(negedge SysClk);
        ResetN = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge SysClk); #1;
            check($sformatf("init_clear_%0d", i), int'({WrtFrameMem, Busy, AdrOut, DataOut}),
                  int'({1'b1, 1'b1, 10'(i), 8'h20}));
        end
        @(posedge SysClk); #1;
        check("init_ready", int'({CharReady, Busy, WrtFrameMem}), int'(3'b100));
        check("init_cursor", int'({CursorCol, CursorRow}), 0);
        @(negedge SysClk); #1;
        act.delete();
        act_cyc.delete();
        m_col = 0;
        m_row = 0;

        // Back-to-back printable characters.
        model_byte(8'h41);
        model_byte(8'h42);
        send(8'h41);
        send(8'h42);
        wait_idle(low);
        check("ab_col", int'(CursorCol), 2);
        check("ab_nwr", act_cyc.size(), 2);
        if (act_cyc.size() == 2) check("ab_consecutive", act_cyc[1] - act_cyc[0], 1);
        check_writes("ab_writes");
        send_chk(8'h0D, low, nwr);

        // Single-byte vector table.
        for (int i = 0; i < 16; i++) begin
            send_chk(tbl[i].ch, low, nwr);
            check($sformatf("tbl%0d_col", i), int'(CursorCol), tbl[i].col);
            check($sformatf("tbl%0d_row", i), int'(CursorRow), tbl[i].row);
            check($sformatf("tbl%0d_nwr", i), nwr, tbl[i].nwr);
        end

        // Printable at column 39 wraps and clears the next row.
        send_chk(8'h0C, low, nwr);
        for (int i = 0; i < 39; i++) send_chk(8'h61, low, nwr);
        send_chk(8'h5A, low, nwr);
        check("wrap_ready_low", low, 40);
        check("wrap_nwr", nwr, 41);
        check("wrap_cursor", int'({CursorCol, CursorRow}), int'({6'd0, 5'd1}));

        // LF on the last row wraps to row 0; CR and BEL then leave it alone.
        send_chk(8'h0C, low, nwr);
        for (int i = 0; i < 24; i++) send_chk(8'h0A, low, nwr);
        for (int i = 0; i < 7; i++) send_chk(8'h71, low, nwr);
        check("row24_cursor", int'({CursorCol, CursorRow}), int'({6'd7, 5'd24}));
        send_chk(8'h0A, low, nwr);
        check("lf_wrap_nwr", nwr, 40);
        check("lf_wrap_cursor", int'({CursorCol, CursorRow}), 0);
        send_chk(8'h0D, low, nwr);
        check("cr_nwr", nwr, 0);
        send_chk(8'h07, low, nwr);
        check("bel_nwr", nwr, 0);

        // Backspace at (5,3), then at column 0.
        send_chk(8'h0C, low, nwr);
        for (int i = 0; i < 3; i++) send_chk(8'h0A, low, nwr);
        for (int i = 0; i < 5; i++) send_chk(8'h62, low, nwr);
        model_byte(8'h08);
        send(8'h08);
        wait_idle(low);
        check("bs_nwr", act.size(), 1);
        if (act.size() == 1) check("bs_write", int'(act[0]), int'({10'd124, 8'h20}));
        check("bs_col", int'(CursorCol), 4);
        check_writes("bs_writes");
        for (int i = 0; i < 4; i++) send_chk(8'h08, low, nwr);
        send_chk(8'h08, low, nwr);
        check("bs_col0_nwr", nwr, 0);
        check("bs_col0_col", int'(CursorCol), 0);

        // Reset pulse in the middle of a screen clear.
        @(negedge SysClk);
        ResetN = 1'b0;
        repeat (2) @(negedge SysClk);
        ResetN = 1'b1;
        repeat (300) @(posedge SysClk);
        #2;
        ResetN = 1'b0;
        #1;
        check("midrst_wrt", int'(WrtFrameMem), 0);
        check("midrst_busy", int'(Busy), 0);
        act.delete();
        act_cyc.delete();
        expq.delete();
        repeat (2) @(negedge SysClk);
        ResetN = 1'b1;
        m_col = 0;
        m_row = 0;
        push_clear_screen();
        wait_idle(low);
        check("midrst_cursor", int'({CursorCol, CursorRow}), 0);
        check_writes("midrst_writes");

        // Random byte stream against the model.
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 68)      c = 8'($urandom_range(32, 126));
            else if (r < 75) c = 8'h0A;
            else if (r < 80) c = 8'h0D;
            else if (r < 86) c = 8'h08;
            else if (r < 88) c = 8'h0C;
            else if (r < 93) c = 8'h09;
            else if (r < 97) c = 8'($urandom_range(128, 255));
            else             c = 8'($urandom_range(0, 31));
            send_chk(c, low, nwr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
